// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants and types for the ALU operation sequencer: MIPS opcode/funct
// codes, ALU select encodings, sequencer states and decoded operation classes.
package alu_op_sequencer_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_NOT = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_SRA = 3'b100;
  localparam logic [2:0] SEL_SLL = 3'b101;
  localparam logic [2:0] SEL_EQ  = 3'b110;
  localparam logic [2:0] SEL_NE  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_NOR,
    OP_SLL,
    OP_SRA,
    OP_SLT,
    OP_BEQ,
    OP_BNE,
    OP_ILL
  } op_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct into operation class, ALU pass count
// and the select code of the first pass. Zero latency, no flow control.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output op_e        op_o,
  output logic [1:0] passes_o,
  output logic [2:0] sel1_o
);

  always_comb begin
    op_o     = OP_ILL;
    passes_o = 2'd0;
    sel1_o   = SEL_ADD;
    case (opcode_i)
      OPC_RTYPE: begin
        case (funct_i)
          FN_ADD: begin op_o = OP_ADD; passes_o = 2'd1; sel1_o = SEL_ADD; end
          FN_SUB: begin op_o = OP_SUB; passes_o = 2'd3; sel1_o = SEL_NOT; end
          FN_AND: begin op_o = OP_AND; passes_o = 2'd1; sel1_o = SEL_AND; end
          FN_OR:  begin op_o = OP_OR;  passes_o = 2'd1; sel1_o = SEL_OR;  end
          FN_NOR: begin op_o = OP_NOR; passes_o = 2'd2; sel1_o = SEL_OR;  end
          FN_SLL: begin op_o = OP_SLL; passes_o = 2'd1; sel1_o = SEL_SLL; end
          FN_SRA: begin op_o = OP_SRA; passes_o = 2'd1; sel1_o = SEL_SRA; end
          FN_SLT: begin op_o = OP_SLT; passes_o = 2'd3; sel1_o = SEL_NOT; end
          default: ;
        endcase
      end
      OPC_BEQ: begin op_o = OP_BEQ; passes_o = 2'd1; sel1_o = SEL_EQ; end
      OPC_BNE: begin op_o = OP_BNE; passes_o = 2'd1; sel1_o = SEL_NE; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the 8-bit combinational ALU over 1-3 passes per MIPS-style request;
// one operation in flight, response held stable until rsp_ready.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] ILLEGAL_RESULT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [5:0]        req_funct,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_ovf,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_ovf,
  output logic              rsp_branch_taken,
  output logic              rsp_illegal
);

  localparam int MSB = DATA_W - 1;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]        pass_q, pass_d, npass_q, npass_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]        alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic              rsp_br_q, rsp_br_d;
  logic              rsp_ill_q, rsp_ill_d;

  op_e        dec_op;
  logic [1:0] dec_passes;
  logic [2:0] dec_sel1;
  logic       sub_ovf;

  alu_op_decode u_decode (
    .opcode_i (req_opcode),
    .funct_i  (req_funct),
    .op_o     (dec_op),
    .passes_o (dec_passes),
    .sel1_o   (dec_sel1)
  );

  // On the final SUB/SLT pass alu_f holds a + (-b); overflow is judged from the
  // original operands so that b = most-negative still reports correctly.
  assign sub_ovf = (a_q[MSB] ^ b_q[MSB]) & (a_q[MSB] ^ alu_f[MSB]);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    pass_d       = pass_q;
    npass_d      = npass_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_br_d     = rsp_br_q;
    rsp_ill_d    = rsp_ill_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = dec_op;
          a_d     = req_a;
          b_d     = req_b;
          pass_d  = 2'd1;
          npass_d = dec_passes;
          if (dec_op == OP_ILL) begin
            rsp_result_d = ILLEGAL_RESULT;
            rsp_ovf_d    = 1'b0;
            rsp_br_d     = 1'b0;
            rsp_ill_d    = 1'b1;
            state_d      = ST_RESP;
          end else begin
            alu_a_d   = req_a;
            alu_b_d   = req_b;
            alu_sel_d = dec_sel1;
            state_d   = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        if (pass_q != npass_q) begin
          pass_d = pass_q + 2'd1;
          case (op_q)
            OP_SUB, OP_SLT: begin
              alu_sel_d = SEL_ADD;
              if (pass_q == 2'd1) begin
                alu_a_d = alu_f;
                alu_b_d = DATA_W'(1);
              end else begin
                alu_a_d = a_q;
                alu_b_d = alu_f;
              end
            end
            OP_NOR: begin
              alu_b_d   = alu_f;
              alu_sel_d = SEL_NOT;
            end
            default: ;
          endcase
        end else begin
          state_d      = ST_RESP;
          rsp_result_d = alu_f;
          rsp_ovf_d    = 1'b0;
          rsp_br_d     = 1'b0;
          rsp_ill_d    = 1'b0;
          case (op_q)
            OP_ADD: rsp_ovf_d = alu_ovf;
            OP_SUB: rsp_ovf_d = sub_ovf;
            OP_SLT: rsp_result_d = {{(DATA_W-1){1'b0}}, alu_f[MSB] ^ sub_ovf};
            OP_BEQ, OP_BNE: begin
              rsp_result_d = '0;
              rsp_br_d     = alu_zero;
            end
            default: ;
          endcase
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      pass_q       <= 2'd0;
      npass_q      <= 2'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= SEL_ADD;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_br_q     <= 1'b0;
      rsp_ill_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      pass_q       <= pass_d;
      npass_q      <= npass_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_br_q     <= rsp_br_d;
      rsp_ill_q    <= rsp_ill_d;
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign rsp_valid        = (state_q == ST_RESP);
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_sel          = alu_sel_q;
  assign rsp_result       = rsp_result_q;
  assign rsp_ovf          = rsp_ovf_q;
  assign rsp_branch_taken = rsp_br_q;
  assign rsp_illegal      = rsp_ill_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, multi-cycle corner cases,
// and random operations checked against an arithmetic reference model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [5:0] req_opcode, req_funct;
  logic [7:0] req_a, req_b;
  logic [7:0] alu_a, alu_b, alu_f;
  logic [2:0] alu_sel;
  logic       alu_ovf, alu_zero;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_ovf, rsp_branch_taken, rsp_illegal;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(8), .ILLEGAL_RESULT(8'h00)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_opcode       (req_opcode),
    .req_funct        (req_funct),
    .req_a            (req_a),
    .req_b            (req_b),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_sel          (alu_sel),
    .alu_f            (alu_f),
    .alu_ovf          (alu_ovf),
    .alu_zero         (alu_zero),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_ovf          (rsp_ovf),
    .rsp_branch_taken (rsp_branch_taken),
    .rsp_illegal      (rsp_illegal)
  );

  // Combinational ALU attached to the sequencer.
  int s_alu;
  always_comb begin
    alu_f    = 8'h00;
    alu_ovf  = 1'b0;
    alu_zero = 1'b0;
    s_alu    = 0;
    case (alu_sel)
      3'b000: begin
        s_alu   = int'($signed(alu_a)) + int'($signed(alu_b));
        alu_f   = s_alu[7:0];
        alu_ovf = (s_alu > 127) || (s_alu < -128);
      end
      3'b001: alu_f = ~alu_b;
      3'b010: alu_f = alu_a & alu_b;
      3'b011: alu_f = alu_a | alu_b;
      3'b100: alu_f = {alu_a[7], alu_a[7:1]};
      3'b101: alu_f = {alu_a[6:0], 1'b0};
      3'b110: alu_zero = (alu_a == alu_b);
      default: alu_zero = (alu_a != alu_b);
    endcase
  end

  typedef struct {
    logic [5:0] opc;
    logic [5:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ovf;
    logic       br;
    logic       ill;
    int         lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_res;
  logic       got_ovf, got_br, got_ill;
  int         got_lat;
  logic [8:0] sel_seq;
  int         sel_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: what the operation means arithmetically, and how long it takes.
  function automatic vec_t model(input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    int sa, sb, s;
    v.opc = opc; v.fn = fn; v.a = a; v.b = b;
    v.res = 8'h00; v.ovf = 1'b0; v.br = 1'b0; v.ill = 1'b0; v.lat = 2;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = 0;
    if (opc == 6'h00) begin
      case (fn)
        6'h20: begin s = sa + sb; v.res = s[7:0]; v.ovf = (s > 127) || (s < -128); end
        6'h22: begin s = sa - sb; v.res = s[7:0]; v.ovf = (s > 127) || (s < -128); v.lat = 4; end
        6'h24: v.res = a & b;
        6'h25: v.res = a | b;
        6'h27: begin v.res = ~(a | b); v.lat = 3; end
        6'h00: begin s = (int'(a) * 2) % 256; v.res = s[7:0]; end
        6'h03: begin s = sa / 2 - ((sa < 0 && (sa % 2) != 0) ? 1 : 0); v.res = s[7:0]; end
        6'h2A: begin v.res = (sa < sb) ? 8'd1 : 8'd0; v.lat = 4; end
        default: begin v.ill = 1'b1; v.lat = 1; end
      endcase
    end else if (opc == 6'h04) begin
      v.br = (a == b);
    end else if (opc == 6'h05) begin
      v.br = (a != b);
    end else begin
      v.ill = 1'b1;
      v.lat = 1;
    end
    return v;
  endfunction

  // Issue one request, follow it to its response, hold rsp_ready low for
  // 'hold' cycles, then consume it. Called and returns #1 after a rising edge.
  task automatic do_op(input logic [5:0] opc, input logic [5:0] fn,
                       input logic [7:0] a, input logic [7:0] b, input int hold);
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1; req_opcode = opc; req_funct = fn; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    got_lat = 1; sel_seq = 9'd0; sel_n = 0;
    while (!rsp_valid && got_lat < 20) begin
      sel_seq = {sel_seq[5:0], alu_sel};
      sel_n++;
      @(posedge clk); #1;
      got_lat++;
    end
    if (!rsp_valid) chk("rsp_valid_timeout", rsp_valid, 1);
    got_res = rsp_result; got_ovf = rsp_ovf; got_br = rsp_branch_taken; got_ill = rsp_illegal;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_result", rsp_result, got_res);
      chk("hold_flags", {rsp_ovf, rsp_branch_taken, rsp_illegal}, {got_ovf, got_br, got_ill});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
  endtask

  task automatic check_vec(input string tag, input vec_t e);
    chk({tag, "_result"}, got_res, e.res);
    chk({tag, "_ovf"}, got_ovf, e.ovf);
    chk({tag, "_branch"}, got_br, e.br);
    chk({tag, "_illegal"}, got_ill, e.ill);
    chk({tag, "_latency"}, got_lat, e.lat);
  endtask

  vec_t vecs[14];
  vec_t e;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = 6'h00; req_funct = 6'h00; req_a = 8'h00; req_b = 8'h00;

    vecs[0]  = '{6'h00, 6'h20, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 2};
    vecs[1]  = '{6'h00, 6'h22, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 4};
    vecs[2]  = '{6'h00, 6'h22, 8'h00, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 4};
    vecs[3]  = '{6'h00, 6'h2A, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 4};
    vecs[4]  = '{6'h00, 6'h2A, 8'h02, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b0, 4};
    vecs[5]  = '{6'h00, 6'h27, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0, 1'b0, 3};
    vecs[6]  = '{6'h04, 6'h00, 8'h12, 8'h12, 8'h00, 1'b0, 1'b1, 1'b0, 2};
    vecs[7]  = '{6'h05, 6'h00, 8'h12, 8'h12, 8'h00, 1'b0, 1'b0, 1'b0, 2};
    vecs[8]  = '{6'h3F, 6'h00, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{6'h00, 6'h24, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{6'h00, 6'h25, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 2};
    vecs[11] = '{6'h00, 6'h00, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 2};
    vecs[12] = '{6'h00, 6'h03, 8'h81, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b0, 2};
    vecs[13] = '{6'h00, 6'h3F, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_fields", {rsp_result, rsp_ovf, rsp_branch_taken, rsp_illegal}, 0);
    chk("reset_alu", {alu_a, alu_b, alu_sel}, 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].opc, vecs[i].fn, vecs[i].a, vecs[i].b, 0);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // SUB pass select sequence.
    do_op(6'h00, 6'h22, 8'h05, 8'h07, 0);
    chk("sub_sel_count", sel_n, 3);
    chk("sub_sel_seq", sel_seq, 9'b001_000_000);

    // Illegal op leaves ALU inputs untouched and holds its response.
    do_op(6'h00, 6'h20, 8'h3C, 8'h41, 0);
    chk("add_3c_41", got_res, 8'h7D);
    do_op(6'h3F, 6'h00, 8'hAA, 8'h55, 3);
    chk("ill_result", got_res, 8'h00);
    chk("ill_flag", got_ill, 1);
    chk("ill_latency", got_lat, 1);
    chk("ill_alu_a", alu_a, 8'h3C);
    chk("ill_alu_b", alu_b, 8'h41);
    chk("ill_alu_sel", alu_sel, 3'b000);

    // Reset during the second SUB pass drops the transaction.
    req_valid = 1'b1; req_opcode = 6'h00; req_funct = 6'h22; req_a = 8'h09; req_b = 8'h03;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_sub_in_pass2", alu_sel, 3'b000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_alu_sel", alu_sel, 3'b000);
    chk("rst_mid_alu_ab", {alu_a, alu_b}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_rsp", rsp_valid, 0);
    end
    do_op(6'h00, 6'h20, 8'h01, 8'h01, 0);
    chk("post_rst_add", got_res, 8'h02);
    chk("post_rst_lat", got_lat, 2);

    // Random operations against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] opc, fn;
      logic [7:0] a, b;
      int k;
      k = $urandom_range(0, 11);
      a = 8'($urandom);
      b = 8'($urandom);
      if (($urandom_range(0, 3) == 0)) b = a;
      opc = 6'h00;
      case (k)
        0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h24;  3: fn = 6'h25;
        4: fn = 6'h27;  5: fn = 6'h00;  6: fn = 6'h03;  7: fn = 6'h2A;
        8: begin opc = 6'h04; fn = 6'($urandom); end
        9: begin opc = 6'h05; fn = 6'($urandom); end
        10: begin opc = 6'($urandom); fn = 6'($urandom); end
        default: fn = 6'($urandom);
      endcase
      e = model(opc, fn, a, b);
      do_op(opc, fn, a, b, $urandom_range(0, 2));
      check_vec($sformatf("rnd%0d_op%0h_fn%0h_a%0h_b%0h", n, opc, fn, a, b), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
